// File: rtl/match_game_core.sv
// Card-matching game engine: cursor, two-pick FSM with card RAM fetch, pair compare,
// mismatch hold timer, match/try counting and win/lose detection.
module match_game_core #(
  parameter int unsigned GRID_W      = 6,
  parameter int unsigned GRID_H      = 6,
  parameter int unsigned SYM_W       = 5,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned MAX_TRIES   = 63,
  localparam int unsigned N          = GRID_W * GRID_H,
  localparam int unsigned LOC_W      = $clog2(N),
  localparam int unsigned TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mv_up,
  input  logic             mv_dn,
  input  logic             mv_lt,
  input  logic             mv_rt,
  input  logic             sel,
  output logic [LOC_W-1:0] sym_addr,
  input  logic [SYM_W-1:0] sym_data,
  output logic [LOC_W-1:0] cursor,
  output logic [N-1:0]     revealed,
  output logic [N-1:0]     matched,
  output logic [LOC_W-1:0] card1_loc,
  output logic [LOC_W-1:0] card2_loc,
  output logic [SYM_W-1:0] card1_sym,
  output logic [SYM_W-1:0] card2_sym,
  output logic [TRY_W-1:0] tries,
  output logic [2:0]       state,
  output logic             game_over,
  output logic             win
);

  localparam int unsigned PAIRS  = N / 2;
  localparam int unsigned CNT_W  = $clog2(PAIRS + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned COL_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPick1   = 3'd1,
    StLoad1   = 3'd2,
    StPick2   = 3'd3,
    StLoad2   = 3'd4,
    StCompare = 3'd5,
    StShow    = 3'd6,
    StDone    = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [N-1:0]     revealed_q, revealed_d;
  logic [N-1:0]     matched_q, matched_d;
  logic [LOC_W-1:0] card1_loc_q, card1_loc_d;
  logic [LOC_W-1:0] card2_loc_q, card2_loc_d;
  logic [SYM_W-1:0] card1_sym_q, card1_sym_d;
  logic [SYM_W-1:0] card2_sym_q, card2_sym_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LOC_W-1:0] addr_q, addr_d;
  logic             win_q, win_d;
  logic             pick_ok;
  logic [N-1:0]     pair_mask;

  assign cursor    = LOC_W'(32'(row_q) * GRID_W + 32'(col_q));
  // A pick is only legal on a face-down, unmatched card.
  assign pick_ok   = sel && !revealed_q[cursor] && !matched_q[cursor];
  assign pair_mask = ({{(N-1){1'b0}}, 1'b1} << card1_loc_q)
                   | ({{(N-1){1'b0}}, 1'b1} << card2_loc_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    revealed_d  = revealed_q;
    matched_d   = matched_q;
    card1_loc_d = card1_loc_q;
    card2_loc_d = card2_loc_q;
    card1_sym_d = card1_sym_q;
    card2_sym_d = card2_sym_q;
    tries_d     = tries_q;
    count_d     = count_q;
    hold_d      = hold_q;
    addr_d      = addr_q;
    win_d       = win_q;

    if (start) begin
      state_d     = StPick1;
      row_d       = '0;
      col_d       = '0;
      revealed_d  = '0;
      matched_d   = '0;
      card1_loc_d = '0;
      card2_loc_d = '0;
      card1_sym_d = '0;
      card2_sym_d = '0;
      tries_d     = '0;
      count_d     = '0;
      hold_d      = '0;
      addr_d      = '0;
      win_d       = 1'b0;
    end else begin
      if (state_q != StIdle && state_q != StDone) begin
        if (mv_up) begin
          row_d = (row_q == '0) ? ROW_W'(GRID_H - 1) : row_q - ROW_W'(1);
        end else if (mv_dn) begin
          row_d = (row_q == ROW_W'(GRID_H - 1)) ? '0 : row_q + ROW_W'(1);
        end else if (mv_lt) begin
          col_d = (col_q == '0) ? COL_W'(GRID_W - 1) : col_q - COL_W'(1);
        end else if (mv_rt) begin
          col_d = (col_q == COL_W'(GRID_W - 1)) ? '0 : col_q + COL_W'(1);
        end
      end

      case (state_q)
        StPick1: begin
          if (pick_ok) begin
            revealed_d[cursor] = 1'b1;
            card1_loc_d        = cursor;
            addr_d             = cursor;
            state_d            = StLoad1;
          end
        end
        StLoad1: begin
          card1_sym_d = sym_data;
          state_d     = StPick2;
        end
        StPick2: begin
          if (pick_ok) begin
            revealed_d[cursor] = 1'b1;
            card2_loc_d        = cursor;
            addr_d             = cursor;
            state_d            = StLoad2;
          end
        end
        StLoad2: begin
          card2_sym_d = sym_data;
          state_d     = StCompare;
        end
        StCompare: begin
          if (card1_sym_q == card2_sym_q) begin
            matched_d = matched_q | pair_mask;
            count_d   = count_q + CNT_W'(1);
            if (count_q == CNT_W'(PAIRS - 1)) begin
              win_d   = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StPick1;
            end
          end else begin
            if (tries_q != TRY_W'(MAX_TRIES)) tries_d = tries_q + TRY_W'(1);
            hold_d  = HOLD_W'(HOLD_CYCLES - 1);
            state_d = StShow;
          end
        end
        StShow: begin
          if (hold_q == '0) begin
            revealed_d = revealed_q & ~pair_mask;
            if (tries_q == TRY_W'(MAX_TRIES)) begin
              win_d   = 1'b0;
              state_d = StDone;
            end else begin
              state_d = StPick1;
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      revealed_q  <= '0;
      matched_q   <= '0;
      card1_loc_q <= '0;
      card2_loc_q <= '0;
      card1_sym_q <= '0;
      card2_sym_q <= '0;
      tries_q     <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      addr_q      <= '0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      revealed_q  <= revealed_d;
      matched_q   <= matched_d;
      card1_loc_q <= card1_loc_d;
      card2_loc_q <= card2_loc_d;
      card1_sym_q <= card1_sym_d;
      card2_sym_q <= card2_sym_d;
      tries_q     <= tries_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      win_q       <= win_d;
    end
  end

  assign sym_addr  = addr_q;
  assign revealed  = revealed_q;
  assign matched   = matched_q;
  assign card1_loc = card1_loc_q;
  assign card2_loc = card2_loc_q;
  assign card1_sym = card1_sym_q;
  assign card2_sym = card2_sym_q;
  assign tries     = tries_q;
  assign state     = state_q;
  assign game_over = (state_q == StDone);
  assign win       = win_q;

endmodule
